morse_letter_sequencer: RTL and testbench

- Plays one Morse letter (A–H) on a single LED with standard unit timing.
- Owns the letter-to-code table and sequences each element as mark then gap, from a divided timebase.
- Sits between the board switches/key and the LED output in the Morse display path.

---
 rtl/morse_letter_sequencer.sv | 151 +++++++++++++++
 tb/tb_morse_letter_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/morse_letter_sequencer.sv
// Plays one Morse letter (A-H) on LEDR with unit timing from a divided clock.
// Optional macro MORSE_REPEAT_EN: repeat the letter while Start stays high.
module morse_letter_sequencer #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic [2:0] SW,
    output logic       LEDR,
    output logic       Busy,
    output logic       Done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MARK = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] FIN  = 3'd3;
`ifdef MORSE_REPEAT_EN
    localparam logic [2:0] LGAP = 3'd4;
`endif

    logic [2:0]       state;
    logic             start_q;
    logic             armed;
    logic [3:0]       pat;
    logic [1:0]       rem;
    logic [1:0]       units;
    logic [CNT_W-1:0] cnt;
    logic             tick;
`ifdef MORSE_REPEAT_EN
    logic [2:0]       letter_q;
    logic             dropped;
`endif

    // Returns {elements remaining after the first, pattern left-aligned MSB-first}.
    function automatic logic [5:0] code_of(input logic [2:0] letter);
        case (letter)
            3'd0:    code_of = {2'd1, 4'b0100};  // A .-
            3'd1:    code_of = {2'd3, 4'b1000};  // B -...
            3'd2:    code_of = {2'd3, 4'b1010};  // C -.-.
            3'd3:    code_of = {2'd2, 4'b1000};  // D -..
            3'd4:    code_of = {2'd0, 4'b0000};  // E .
            3'd5:    code_of = {2'd3, 4'b0010};  // F ..-.
            3'd6:    code_of = {2'd2, 4'b1100};  // G --.
            default: code_of = {2'd3, 4'b0000};  // H ....
        endcase
    endfunction

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            armed    <= 1'b0;
            pat      <= '0;
            rem      <= '0;
            units    <= '0;
            cnt      <= '0;
            LEDR     <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
`ifdef MORSE_REPEAT_EN
            letter_q <= '0;
            dropped  <= 1'b0;
`endif
        end else begin
            start_q <= Start;
            // A Start held through reset release must be seen low before it can trigger.
            if (!Start) armed <= 1'b1;
            Done <= 1'b0;
            cnt  <= tick ? '0 : cnt + 1'b1;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (Start && !start_q && armed) begin
                        {rem, pat} <= code_of(SW);
                        units      <= '0;
                        LEDR       <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= MARK;
`ifdef MORSE_REPEAT_EN
                        letter_q   <= SW;
`endif
                    end
                end
                MARK: if (tick) begin
                    if (units == (pat[3] ? 2'd2 : 2'd0)) begin
                        units <= '0;
                        LEDR  <= 1'b0;
                        state <= GAP;
                    end else begin
                        units <= units + 1'b1;
                    end
                end
                GAP: if (tick) begin
                    if (rem != 2'd0) begin
                        rem   <= rem - 1'b1;
                        pat   <= {pat[2:0], 1'b0};
                        LEDR  <= 1'b1;
                        state <= MARK;
                    end else begin
                        Done  <= 1'b1;
                        state <= FIN;
`ifdef MORSE_REPEAT_EN
                        if (!Start) Busy <= 1'b0;
`else
                        Busy  <= 1'b0;
`endif
                    end
                end
                FIN: begin
                    cnt <= '0;
`ifdef MORSE_REPEAT_EN
                    // Busy still high here means the letter is being repeated.
                    dropped <= 1'b0;
                    state   <= Busy ? LGAP : IDLE;
`else
                    state   <= IDLE;
`endif
                end
`ifdef MORSE_REPEAT_EN
                LGAP: begin
                    if (!Start) dropped <= 1'b1;
                    if (tick) begin
                        if (units == 2'd1) begin
                            units <= '0;
                            if (dropped || !Start) begin
                                Busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                {rem, pat} <= code_of(letter_q);
                                LEDR       <= 1'b1;
                                state      <= MARK;
                            end
                        end else begin
                            units <= units + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Self-checking bench for morse_letter_sequencer (default build, TICK_DIV=4).
module tb_morse_letter_sequencer;

    localparam int TD = 4;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Start;
    logic [2:0] SW;
    logic       LEDR;
    logic       Busy;
    logic       Done;

    int errors = 0;
    int checks = 0;

    string codes[8] = '{"01", "1000", "1010", "100", "0", "0010", "110", "0000"};
    bit    wave[$];

    typedef struct {
        int letter;
        int busy_cycles;
    } vec_t;

    always #5 Clock = ~Clock;

    morse_letter_sequencer #(.TICK_DIV(TD), .CNT_W(4)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Start (Start),
        .SW    (SW),
        .LEDR  (LEDR),
        .Busy  (Busy),
        .Done  (Done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected LEDR per cycle after acceptance: each element is mark then one-unit gap.
    function automatic void build_wave(input int l);
        wave.delete();
        for (int e = 0; e < codes[l].len(); e++) begin
            int m;
            m = (codes[l].getc(e) == "1") ? 3 : 1;
            repeat (m * TD) wave.push_back(1'b1);
            repeat (TD) wave.push_back(1'b0);
        end
    endfunction

    // Plays letter l; outputs sampled on falling edges as {LEDR,Busy,Done}.
    task automatic play(input int l, input bit hold, input bit disturb, input int abort_at,
                        output int busy_n, output int done_n);
        int n;
        logic [2:0] exp;
        string nm;
        build_wave(l);
        n = wave.size();
        busy_n = 0;
        done_n = 0;
        @(negedge Clock) Start = 1'b0;
        @(negedge Clock) begin
            SW    = 3'(l);
            Start = 1'b1;
        end
        for (int k = 1; k <= n + 10; k++) begin
            @(negedge Clock);
            exp = {(k <= n) ? logic'(wave[k-1]) : 1'b0, logic'(k <= n), logic'(k == n + 1)};
            nm = $sformatf("%c k=%0d out", 8'd65 + 8'(l), k);
            check(nm, int'({LEDR, Busy, Done}), int'(exp));
            busy_n += int'(Busy);
            done_n += int'(Done);
            if (k == 1 && !hold) Start = 1'b0;
            if (disturb && k == n / 2) begin
                SW    = ~SW;
                Start = 1'b1;
            end
            if (disturb && k == n / 2 + 1) Start = 1'b0;
            if (k == abort_at) begin
                Resetn = 1'b0;
                #1;
                check("async_abort", int'({LEDR, Busy, Done}), 0);
                return;
            end
        end
        Start = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int b, d;
        vecs[0] = '{0, 24};
        vecs[1] = '{1, 40};
        vecs[2] = '{2, 48};
        vecs[3] = '{3, 32};
        vecs[4] = '{4, 8};
        vecs[5] = '{5, 40};
        vecs[6] = '{6, 40};
        vecs[7] = '{7, 32};

        // Reset with Start held high through release: no playback.
        Resetn = 1'b0;
        Start  = 1'b1;
        SW     = 3'd0;
        repeat (3) @(negedge Clock);
        check("reset_out", int'({LEDR, Busy, Done}), 0);
        Resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("held_start_idle", int'({LEDR, Busy, Done}), 0);
        end

        // Every letter from the table.
        foreach (vecs[i]) begin
            play(vecs[i].letter, 1'b0, 1'b0, 0, b, d);
            check($sformatf("busy_count_%0d", vecs[i].letter), b, vecs[i].busy_cycles);
            check($sformatf("done_count_%0d", vecs[i].letter), d, 1);
        end

        // C with SW change and Start re-pulse mid-letter.
        play(2, 1'b0, 1'b1, 0, b, d);
        check("C_disturb_busy", b, 48);
        check("C_disturb_done", d, 1);

        // E with Start held across FIN: no retrigger.
        play(4, 1'b1, 1'b0, 0, b, d);
        check("E_hold_done", d, 1);

        // H aborted by reset in its third mark, then replayed from the first dot.
        play(7, 1'b0, 1'b0, 18, b, d);
        check("abort_no_done", d, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("abort_held", int'({LEDR, Busy, Done}), 0);
        end
        @(negedge Clock) Resetn = 1'b1;
        play(7, 1'b0, 1'b0, 0, b, d);
        check("H_replay_busy", b, 32);
        check("H_replay_done", d, 1);

        // Randomized letters with random holds and mid-letter disturbances.
        for (int i = 0; i < 12; i++) begin
            int l;
            l = int'($urandom_range(0, 7));
            play(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, b, d);
            check($sformatf("rand_busy_%0d", l), b, vecs[l].busy_cycles);
            check($sformatf("rand_done_%0d", l), d, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
